// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I/D-cache to main-memory arbiter.
// Requester index 1 is the D-side miss handler, index 0 the I-side.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WRITE      = 2'd1,
    ST_FILL_ISSUE = 2'd2,
    ST_FILL_DRAIN = 2'd3
  } state_t;

  localparam int REQ_I               = 0;
  localparam int REQ_D               = 1;
  localparam int DATA_WIDTH          = 16;
  localparam int DEF_ADDR_WIDTH      = 16;
  localparam int DEF_WORDS_PER_BLOCK = 8;
  localparam int DEF_MEM_LAT         = 4;

  function automatic logic [1:0] side_onehot(input logic side);
    if (side == 1'(REQ_D)) begin
      side_onehot = 2'b10;
    end else begin
      side_onehot = 2'b01;
    end
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; on a tie the side other than the last
// granted one wins, and the pointer moves only when a grant is taken.
module rr_arb2 import mem_arb_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic       valid,
  output logic       pick
);

  logic last;

  // Winner selection from the live request vector.
  always_comb begin
    valid = |req;
    pick  = 1'(REQ_I);
    if (req == 2'b11) begin
      pick = ~last;
    end else if (req[REQ_D]) begin
      pick = 1'(REQ_D);
    end else begin
      pick = 1'(REQ_I);
    end
  end

  // Last-granted pointer; I-side after reset so D wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'(REQ_I);
    end else if (update) begin
      last <= pick;
    end else begin
      last <= last;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I/D cache miss traffic onto one pipelined 16-bit memory:
// single-word writes, and 8-word block fills steered back to the owner.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter  int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter  int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter  int MEM_LAT         = DEF_MEM_LAT,
  localparam int IDX_W           = $clog2(WORDS_PER_BLOCK)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic [1:0]            req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  input  logic [DATA_WIDTH-1:0] req_wdata0,
  input  logic [DATA_WIDTH-1:0] req_wdata1,
  output logic [1:0]            gnt,
  output logic                  fill_valid,
  output logic [IDX_W-1:0]      fill_idx,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic [1:0]            done,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_data_valid
);

  localparam int               OFF_W    = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

  if (WORDS_PER_BLOCK < 2 || MEM_LAT < 1 || ADDR_WIDTH <= OFF_W) begin : g_bad_param
    $error("mem_arbiter: unsupported parameter combination");
  end

  state_t                state, state_next;
  logic                  owner;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [IDX_W-1:0]      issue_cnt;
  logic [IDX_W-1:0]      ret_cnt;
  logic                  arb_valid, arb_pick, arb_update;
  logic                  in_fill, ret_hit, ret_last;
  logic [ADDR_WIDTH-1:0] req_addr_sel, fill_base, issue_addr;
  logic [DATA_WIDTH-1:0] req_wdata_sel;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .update (arb_update),
    .valid  (arb_valid),
    .pick   (arb_pick)
  );

  // Requester-side muxing and address arithmetic (wraps mod 2^ADDR_WIDTH).
  always_comb begin
    req_addr_sel  = arb_pick ? req_addr1 : req_addr0;
    req_wdata_sel = arb_pick ? req_wdata1 : req_wdata0;
    fill_base     = {req_addr_sel[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    issue_addr    = cmd_addr + {{(ADDR_WIDTH-OFF_W){1'b0}}, issue_cnt, 1'b0};
    in_fill       = (state == ST_FILL_ISSUE) || (state == ST_FILL_DRAIN);
    ret_hit       = in_fill && mem_data_valid;
    ret_last      = ret_hit && (ret_cnt == LAST_IDX);
  end

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    state_next = state;
    arb_update = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          arb_update = 1'b1;
          state_next = req_wr[arb_pick] ? ST_WRITE : ST_FILL_ISSUE;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WRITE: begin
        state_next = ST_IDLE;
      end
      ST_FILL_ISSUE: begin
        if (ret_last) begin
          state_next = ST_IDLE;
        end else if (issue_cnt == LAST_IDX) begin
          state_next = ST_FILL_DRAIN;
        end else begin
          state_next = ST_FILL_ISSUE;
        end
      end
      ST_FILL_DRAIN: begin
        if (ret_last) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_FILL_DRAIN;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output decode from state, owner and counters.
  always_comb begin
    gnt         = 2'b00;
    fill_valid  = 1'b0;
    fill_idx    = {IDX_W{1'b0}};
    fill_data   = {DATA_WIDTH{1'b0}};
    done        = 2'b00;
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = {ADDR_WIDTH{1'b0}};
    mem_data_in = {DATA_WIDTH{1'b0}};
    if (state != ST_IDLE) begin
      gnt = side_onehot(owner);
    end else begin
      gnt = 2'b00;
    end
    if (ret_hit) begin
      fill_valid = 1'b1;
      fill_idx   = ret_cnt;
      fill_data  = mem_data_out;
    end else begin
      fill_valid = 1'b0;
    end
    case (state)
      ST_WRITE: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = cmd_addr;
        mem_data_in = cmd_wdata;
        done        = side_onehot(owner);
      end
      ST_FILL_ISSUE: begin
        mem_enable = 1'b1;
        mem_addr   = issue_addr;
        done       = ret_last ? side_onehot(owner) : 2'b00;
      end
      ST_FILL_DRAIN: begin
        done = ret_last ? side_onehot(owner) : 2'b00;
      end
      default: begin
        done = 2'b00;
      end
    endcase
  end

  // State, captured command and counters; the command is latched at grant
  // so a requester may drop req or change its address mid-transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= 1'b0;
      cmd_addr  <= {ADDR_WIDTH{1'b0}};
      cmd_wdata <= {DATA_WIDTH{1'b0}};
      issue_cnt <= {IDX_W{1'b0}};
      ret_cnt   <= {IDX_W{1'b0}};
    end else begin
      state <= state_next;
      if (arb_update) begin
        owner     <= arb_pick;
        cmd_addr  <= req_wr[arb_pick] ? req_addr_sel : fill_base;
        cmd_wdata <= req_wdata_sel;
      end else begin
        owner     <= owner;
        cmd_addr  <= cmd_addr;
        cmd_wdata <= cmd_wdata;
      end
      if (state == ST_FILL_ISSUE) begin
        issue_cnt <= issue_cnt + IDX_W'(1);
      end else begin
        issue_cnt <= {IDX_W{1'b0}};
      end
      if (state == ST_IDLE) begin
        ret_cnt <= {IDX_W{1'b0}};
      end else if (ret_hit) begin
        ret_cnt <= ret_cnt + IDX_W'(1);
      end else begin
        ret_cnt <= ret_cnt;
      end
    end
  end

endmodule
